cla_8bits: RTL and testbench

- Registered unsigned adder of width WIDTH2, built from 8-bit carry-lookahead (CLA) blocks tied together by a group-level lookahead carry unit.
- Sums two WIDTH2-bit operands and produces a (WIDTH2+1)-bit result that includes the carry-out.
- Used as a wide-adder datapath primitive; the default is a 64-bit configuration.

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla_block_8.sv | 50 +++++
 rtl/cla_8bits.sv | 64 ++++++
 tb/tb_cla_8bits.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder family.
package cla_pkg;

  localparam int unsigned CLA_BLOCK_W = 8;

  // Number of CLA blocks needed to cover an operand of the given width
  function automatic int unsigned cla_num_blocks(input int unsigned width);
    return width / CLA_BLOCK_W;
  endfunction

endpackage

// File: rtl/cla_block_8.sv
// 8-bit carry-lookahead block: flat lookahead carries plus group generate/propagate.
module cla_block_8
  import cla_pkg::*;
(
  input  logic [CLA_BLOCK_W-1:0] a,
  input  logic [CLA_BLOCK_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_BLOCK_W-1:0] sum,
  output logic                   G,
  output logic                   P
);

  logic [CLA_BLOCK_W-1:0] g;
  logic [CLA_BLOCK_W-1:0] p;
  logic [CLA_BLOCK_W-1:0] c;

  // Each carry is a sum of products over g/p/cin; no carry depends on another
  always_comb begin
    logic term;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i < int'(CLA_BLOCK_W); i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
  end

  assign sum = p ^ c;

  // Group generate: some bit generates and every bit above it propagates
  always_comb begin
    logic term;
    G = 1'b0;
    for (int j = 0; j < int'(CLA_BLOCK_W); j++) begin
      term = g[j];
      for (int k = j + 1; k < int'(CLA_BLOCK_W); k++) term = term & p[k];
      G = G | term;
    end
  end

  assign P = &p;

endmodule

// File: rtl/cla_8bits.sv
// Registered WIDTH2-bit unsigned adder from 8-bit CLA blocks and a group lookahead unit.
module cla_8bits
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH2 = 64
) (
  input  logic              clk_pi,
  input  logic              rst_n_pi,
  input  logic [WIDTH2-1:0] a_pi,
  input  logic [WIDTH2-1:0] b_pi,
  output logic [WIDTH2:0]   result_po
);

  localparam int unsigned NB = cla_num_blocks(WIDTH2);

  generate
    if ((WIDTH2 % CLA_BLOCK_W) != 0 || WIDTH2 < CLA_BLOCK_W) begin : g_bad_width
      $error("cla_8bits: WIDTH2 must be a non-zero multiple of 8");
    end
  endgenerate

  logic [NB-1:0]     grp_g;
  logic [NB-1:0]     grp_p;
  logic [NB:0]       grp_c;
  logic [WIDTH2-1:0] sum_w;
  logic [WIDTH2:0]   result_d;
  logic [WIDTH2:0]   result_q;

  for (genvar k = 0; k < int'(NB); k++) begin : g_blk
    cla_block_8 u_blk (
      .a   (a_pi[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .b   (b_pi[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .cin (grp_c[k]),
      .sum (sum_w[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  // Second-level lookahead: group carries from lower G/P only, carry-in tied low
  always_comb begin
    logic term;
    grp_c = '0;
    for (int i = 1; i <= int'(NB); i++) begin
      for (int j = 0; j < i; j++) begin
        term = grp_g[j];
        for (int k = j + 1; k < i; k++) term = term & grp_p[k];
        grp_c[i] = grp_c[i] | term;
      end
    end
  end

  always_comb begin
    result_d = {grp_c[NB], sum_w};
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) result_q <= '0;
    else           result_q <= result_d;
  end

  assign result_po = result_q;

endmodule

// File: tb/tb_cla_8bits.sv
// Self-checking bench: 64/16/8-bit adders against an arithmetic reference model.
module tb_cla_8bits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [64:0] res64;
  logic [16:0] res16;
  logic [8:0]  res8;

  logic [64:0] exp64;
  logic [16:0] exp16;
  logic [8:0]  exp8;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  cla_8bits #(.WIDTH2(64)) dut64 (
    .clk_pi(clk), .rst_n_pi(rst_n), .a_pi(a), .b_pi(b), .result_po(res64));
  cla_8bits #(.WIDTH2(16)) dut16 (
    .clk_pi(clk), .rst_n_pi(rst_n), .a_pi(a[15:0]), .b_pi(b[15:0]), .result_po(res16));
  cla_8bits #(.WIDTH2(8)) dut8 (
    .clk_pi(clk), .rst_n_pi(rst_n), .a_pi(a[7:0]), .b_pi(b[7:0]), .result_po(res8));

  // Reference: full-width sum of the operands seen at the last edge, zero under reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp64 <= '0;
      exp16 <= '0;
      exp8  <= '0;
    end else begin
      exp64 <= 65'(a) + 65'(b);
      exp16 <= 17'(a[15:0]) + 17'(b[15:0]);
      exp8  <= 9'(a[7:0]) + 9'(b[7:0]);
    end
  end

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model64", res64, exp64);
      check("model16", 65'(res16), 65'(exp16));
      check("model8",  65'(res8),  65'(exp8));
    end
  end

  task automatic drive(input logic [63:0] av, input logic [63:0] bv);
    a = av;
    b = bv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [64:0] want;
    #1 rst_n = 1'b0;
    drive('1, '1);
    cmp_en = 1'b1;
    repeat (2) tick();
    check("reset_hold64", res64, 65'h0);
    check("reset_hold8", 65'(res8), 65'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_max", res64, 65'h1_FFFF_FFFF_FFFF_FFFE);
    check("post_reset_max8", 65'(res8), 65'h1FE);

    for (int i = 0; i < 10; i++) begin
      tick();
      check("repeat_max", res64, 65'h1_FFFF_FFFF_FFFF_FFFE);
    end

    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    tick();
    check("full_chain64", res64, 65'h1_0000_0000_0000_0000);
    check("full_chain16", 65'(res16), 65'h1_0000);

    drive(64'hFF, 64'h1);
    tick();
    check("grp_boundary64", res64, 65'h100);
    check("grp_boundary16", 65'(res16), 65'h100);
    check("grp_boundary8", 65'(res8), 65'h100);

    drive(64'h0, 64'h0);
    tick();
    check("zero", res64, 65'h0);

    drive(64'h1234_5678_9ABC_DEF0, 64'h0);
    tick();
    check("identity64", res64, 65'h0_1234_5678_9ABC_DEF0);
    check("identity16", 65'(res16), 65'hDEF0);

    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    tick();
    check("msb_carry", res64, 65'h1_0000_0000_0000_0000);

    for (int i = 0; i < 1000; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end

    // Mid-operation reset between edges
    for (int i = 0; i < 3; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end
    #1 rst_n = 1'b0;
    #1 check("midop_reset_async", res64, 65'h0);
    tick();
    check("midop_reset_hold", res64, 65'h0);
    drive(64'hDEAD_BEEF_0123_4567, 64'hF00D_CAFE_89AB_CDEF);
    rst_n = 1'b1;
    want = 65'h1_CEBB_89ED_8ACF_1356;
    tick();
    check("midop_reset_release", res64, want);

    for (int i = 0; i < 50; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end
    tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
